// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: multi-cycle BCD-to-binary converter (reverse double-dabble).
// Each SHIFT cycle shifts {digits, acc} right by one bit, then subtracts 3 from
// every digit that is >= 8. After BIN_WIDTH shifts the accumulator holds the
// binary value. Valid/ready handshakes on input and output, no overlap.
// Optional feature macro: BCD_DIGIT_CHECK_EN (flags operands with a digit > 9).
module bcd_to_bin_seq #(
    parameter int NUM_DIGITS = 6,
    parameter int BIN_WIDTH  = 20
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [4*NUM_DIGITS-1:0] bcd_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [BIN_WIDTH-1:0]    bin_o,
    output logic                    error_o
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(BIN_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state, state_nx;
    logic [DW-1:0]        digits, digits_nx;
    logic [BIN_WIDTH-1:0] acc, acc_nx;
    logic [CW-1:0]        cnt;
    logic                 accept;
    logic                 last;

    assign accept = in_valid_i && in_ready_o;
    // The cycle after the BIN_WIDTH-th shift publishes the result.
    assign last   = (cnt == CW'(BIN_WIDTH));

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx    = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) state_nx = SHIFT;
            end
            SHIFT: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // One reverse double-dabble step: joint right shift, then per-digit -3 correction.
    always_comb begin
        {digits_nx, acc_nx} = {digits, acc} >> 1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digits_nx[4*i+3]) digits_nx[4*i +: 4] = digits_nx[4*i +: 4] - 4'd3;
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic bad_digit;
    logic err_q;

    // Any operand digit above 9 marks the conversion as invalid.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_i[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end

    // Sticky per-conversion error flag, refreshed on every accept.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)    err_q <= 1'b0;
        else if (accept) err_q <= bad_digit;
    end

    assign error_o = err_q && (state == DONE);
`else
    assign error_o = 1'b0;
`endif

    // Datapath: operand load, shift steps, result capture.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            digits <= '0;
            acc    <= '0;
            cnt    <= '0;
            bin_o  <= '0;
        end else if (accept) begin
            digits <= bcd_i;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == SHIFT) begin
            if (last) begin
`ifdef BCD_DIGIT_CHECK_EN
                bin_o <= err_q ? '0 : acc;
`else
                bin_o <= acc;
`endif
            end else begin
                digits <= digits_nx;
                acc    <= acc_nx;
                cnt    <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: default instance (6 digits, 20 bits) and
// a small instance (2 digits, 7 bits). Drivers push expected results, monitors
// pop and compare whenever a result is presented.
module tb_bcd_to_bin_seq;

    typedef struct {
        logic [19:0] bin;
        logic        err;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv1 = 1'b0, ir1, ov1, ordy1 = 1'b1, err1;
    logic [23:0] bcd1 = '0;
    logic [19:0] bin1;
    logic        iv2 = 1'b0, ir2, ov2, ordy2 = 1'b1, err2;
    logic [7:0]  bcd2 = '0;
    logic [6:0]  bin2;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int n_acc1 = 0, n_done1 = 0, n_abt1 = 0;
    int n_acc2 = 0, n_done2 = 0;
    exp_t q1[$], q2[$];
    exp_t e1, e2;
    logic pv1 = 1'b0, pv2 = 1'b0;
    logic [19:0] hb1;
    logic [6:0]  hb2;

    bcd_to_bin_seq u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(iv1), .in_ready_o(ir1), .bcd_i(bcd1),
        .out_valid_o(ov1), .out_ready_i(ordy1), .bin_o(bin1), .error_o(err1)
    );

    bcd_to_bin_seq #(.NUM_DIGITS(2), .BIN_WIDTH(7)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(iv2), .in_ready_o(ir2), .bcd_i(bcd2),
        .out_valid_o(ov2), .out_ready_i(ordy2), .bin_o(bin2), .error_o(err2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor for the default instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            pv1 <= 1'b0;
        end else begin
            if (n_acc1 != n_done1 + n_abt1) chk("d1_in_ready_busy", 32'(ir1), 32'd0);
            if (ov1 && !pv1) begin
                if (q1.size() == 0) chk("d1_unexpected_out", 32'd1, 32'd0);
                else begin
                    e1 = q1[0];
                    chk("d1_bin", 32'(bin1), 32'(e1.bin));
                    chk("d1_err", 32'(err1), 32'(e1.err));
                    chk("d1_latency", 32'(cyc - e1.acc), 32'd21);
                    hb1 = bin1;
                end
            end else if (ov1) begin
                chk("d1_bin_hold", 32'(bin1), 32'(hb1));
            end
            if (ov1 && ordy1) begin
                if (q1.size() != 0) void'(q1.pop_front());
                n_done1 <= n_done1 + 1;
            end
            pv1 <= ov1;
        end
    end

    // Monitor for the small instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            pv2 <= 1'b0;
        end else begin
            if (n_acc2 != n_done2) chk("d2_in_ready_busy", 32'(ir2), 32'd0);
            if (ov2 && !pv2) begin
                if (q2.size() == 0) chk("d2_unexpected_out", 32'd1, 32'd0);
                else begin
                    e2 = q2[0];
                    chk("d2_bin", 32'(bin2), 32'(e2.bin));
                    chk("d2_err", 32'(err2), 32'(e2.err));
                    chk("d2_latency", 32'(cyc - e2.acc), 32'd8);
                    hb2 = bin2;
                end
            end else if (ov2) begin
                chk("d2_bin_hold", 32'(bin2), 32'(hb2));
            end
            if (ov2 && ordy2) begin
                if (q2.size() != 0) void'(q2.pop_front());
                n_done2 <= n_done2 + 1;
            end
            pv2 <= ov2;
        end
    end

    task automatic send1(input logic [23:0] v, input logic [19:0] eb, input logic ee, input bit expect_out);
        int t = 0;
        while (!ir1 && t < 200) begin @(posedge clk); #1; t++; end
        if (!ir1) chk("d1_accept_timeout", 32'd0, 32'd1);
        iv1 = 1'b1; bcd1 = v;
        @(posedge clk); #1;
        iv1 = 1'b0;
        n_acc1++;
        if (expect_out) q1.push_back('{eb, ee, cyc});
    endtask

    task automatic send2(input logic [7:0] v, input logic [6:0] eb);
        int t = 0;
        while (!ir2 && t < 200) begin @(posedge clk); #1; t++; end
        if (!ir2) chk("d2_accept_timeout", 32'd0, 32'd1);
        iv2 = 1'b1; bcd2 = v;
        @(posedge clk); #1;
        iv2 = 1'b0;
        n_acc2++;
        q2.push_back('{20'(eb), 1'b0, cyc});
    endtask

    task automatic wait_idle1();
        int t = 0;
        while (n_acc1 != n_done1 + n_abt1 && t < 300) begin @(posedge clk); #1; t++; end
        if (n_acc1 != n_done1 + n_abt1) chk("d1_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle2();
        int t = 0;
        while (n_acc2 != n_done2 && t < 300) begin @(posedge clk); #1; t++; end
        if (n_acc2 != n_done2) chk("d2_done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int t;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(ir1), 32'd1);
        chk("rst_out_valid", 32'(ov1), 32'd0);
        chk("rst_bin", 32'(bin1), 32'd0);
        chk("rst_err", 32'(err1), 32'd0);
        chk("rst2_in_ready", 32'(ir2), 32'd1);
        chk("rst2_out_valid", 32'(ov2), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send1(24'h123456, 20'h1E240, 1'b0, 1'b1);
        wait_idle1();
        send1(24'h999999, 20'hF423F, 1'b0, 1'b1);
        send1(24'h000000, 20'h00000, 1'b0, 1'b1);
        wait_idle1();

        // Back-pressure: hold the result for 10 cycles.
        ordy1 = 1'b0;
        send1(24'h000255, 20'd255, 1'b0, 1'b1);
        t = 0;
        while (!ov1 && t < 100) begin @(posedge clk); #1; t++; end
        chk("bp_valid_seen", 32'(ov1), 32'd1);
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_valid_held", 32'(ov1), 32'd1);
            chk("bp_in_ready_low", 32'(ir1), 32'd0);
        end
        ordy1 = 1'b1;
        @(posedge clk); #1;
        chk("bp_valid_drop", 32'(ov1), 32'd0);
        chk("bp_in_ready_back", 32'(ir1), 32'd1);
        wait_idle1();

        // Abort mid-SHIFT with a one-edge reset.
        send1(24'h777777, 20'd0, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_abt1++;
        chk("abort_out_valid", 32'(ov1), 32'd0);
        chk("abort_bin", 32'(bin1), 32'd0);
        chk("abort_in_ready", 32'(ir1), 32'd1);
        send1(24'h000042, 20'd42, 1'b0, 1'b1);
        wait_idle1();

`ifdef BCD_DIGIT_CHECK_EN
        send1(24'h12A456, 20'd0, 1'b1, 1'b1);
`endif
        send1(24'h000010, 20'd10, 1'b0, 1'b1);
        wait_idle1();

        send2(8'h99, 7'd99);
        send2(8'h07, 7'd7);
        wait_idle2();

        repeat (3) @(posedge clk);
        chk("d1_queue_empty", 32'(q1.size()), 32'd0);
        chk("d2_queue_empty", 32'(q2.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
